ifetch_queue: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Accepts the 32-bit PC value, issues one instruction-memory read per PC, and captures the returned instruction together with its PC.
- Buffers fetched instructions in a small queue that feeds decode through a valid/ready handshake.
- Supports flush on taken branch/jump.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/ifetch_queue.sv | 136 +++++++++++++
 tb/tb_ifetch_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch stage.
// IFETCH_ALIGN_CHECK_EN adds a per-entry misalign flag to the queue entry.
package mips_pkg;

    localparam int                WORD_W    = 32;
    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
`ifdef IFETCH_ALIGN_CHECK_EN
        logic              misalign;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO of fetched {pc, instr} entries with a synchronous clear.
// Entry layout depends on IFETCH_ALIGN_CHECK_EN through mips_pkg::fetch_entry_t.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Clear wins over both push and pop in the same cycle.
    assign do_push = push && !clear && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && !clear && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entries are reset so the head reads RESET_PC / NOP straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]       <= '0;
                mem_q[i].pc    <= RESET_PC;
                mem_q[i].instr <= INSTR_NOP;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: one instruction-memory read per accepted PC, results queued for decode.
// Defining IFETCH_ALIGN_CHECK_EN adds id_misalign and bypasses memory for unaligned PCs.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc_plus4
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic              id_misalign
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] addr_d;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Room check uses the registered count only, keeping id_ready off the pc_ready path.
    assign pc_ready = !rst && (state_q == IDLE) && !flush
                      && (fifo_count < CNT_W'(DEPTH));

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        fifo_push        = 1'b0;
        push_entry       = '0;
        push_entry.pc    = addr_q;
        push_entry.instr = imem_rdata;
        case (state_q)
            IDLE: begin
                if (pc_valid && pc_ready) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (pc_in[1:0] != 2'b00) begin
                        fifo_push           = 1'b1;
                        push_entry.pc       = pc_in;
                        push_entry.instr    = INSTR_NOP;
                        push_entry.misalign = 1'b1;
                    end else begin
                        addr_d  = pc_in;
                        state_d = REQ;
                    end
`else
                    addr_d  = pc_in;
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                // A grant coinciding with flush leaves a response in flight to drain.
                if (flush) begin
                    state_d = imem_gnt ? DRAIN : IDLE;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    fifo_push = !flush;
                    state_d   = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = addr_q;
    assign fifo_pop  = id_valid && id_ready;

    fetch_fifo #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (fifo_count)
    );

    assign id_valid    = (fifo_count != '0);
    assign id_instr    = head_entry.instr;
    assign id_pc       = head_entry.pc;
    assign id_pc_plus4 = head_entry.pc + 32'd4;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign id_misalign = head_entry.misalign;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios followed by a randomized run
// against a queue-level reference model. Covers id_misalign when IFETCH_ALIGN_CHECK_EN is set.
module tb_ifetch_queue;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        id_misalign;
`endif

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_grant = 0;

    // Memory timing knobs used by the responder.
    int gnt_lat  = 0;
    int rv_lat   = 1;
    bit rand_lat = 1'b0;
    bit prev_fl  = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;
    exp_t expq[$];

    ifetch_queue #(
        .DEPTH    (2),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .id_misalign (id_misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        if (a == 32'h0000_0300) return 32'hDEAD_BEEF;
        return {a[15:0], a[31:16]} ^ 32'h8C21_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction memory: grant after a latency, return data a few cycles after the grant.
    initial begin
        int          req_cnt;
        int          cur_gnt;
        int          rv_cnt;
        logic [31:0] held_addr;
        logic [31:0] rd_addr;
        req_cnt = 0; cur_gnt = 0; rv_cnt = -1; held_addr = '0; rd_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
            if (rst) begin
                req_cnt = 0;
                rv_cnt  = -1;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = imem_word(rd_addr);
                        rv_cnt      = -1;
                    end
                end
                if (imem_req && rv_cnt < 0) begin
                    if (req_cnt == 0) begin
                        cur_gnt   = rand_lat ? int'($urandom_range(0, 3)) : gnt_lat;
                        held_addr = imem_addr;
                    end else begin
                        chk("req_addr_stable", imem_addr, held_addr);
                    end
                    if (req_cnt >= cur_gnt) begin
                        imem_gnt = 1'b1;
                        rd_addr  = imem_addr;
                        rv_cnt   = rand_lat ? int'($urandom_range(1, 3)) : rv_lat;
                        req_cnt  = 0;
                        n_grant++;
                    end else begin
                        req_cnt++;
                    end
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    // One clock cycle: drive inputs at the falling edge, then update/check the model.
    task automatic step(input bit pv, input logic [31:0] pc, input bit fl, input bit rdy,
                        output bit acc);
        exp_t e;
        @(negedge clk);
        pc_valid = pv; pc_in = pc; flush = fl; id_ready = rdy;
        #1;
        acc = pc_valid && pc_ready;
        if (prev_fl) chk("id_valid_after_flush", id_valid, 0);
        if (fl) begin
            chk("pc_ready_during_flush", pc_ready, 0);
            expq.delete();
        end else begin
            if (id_valid && id_ready) begin
                n_cmp++;
                assert (expq.size() != 0) else begin
                    n_bad++;
                    $error("FAIL pop_nothing_expected observed=id_valid=1 expected=empty queue");
                end
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("pop_pc", id_pc, e.pc);
                    chk("pop_instr", id_instr, e.instr);
                    chk("pop_pc_plus4", id_pc_plus4, e.pc + 32'd4);
`ifdef IFETCH_ALIGN_CHECK_EN
                    chk("pop_misalign", id_misalign, e.mis);
`endif
                end
            end
            if (acc) begin
                e.pc  = pc_in;
                e.mis = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
                e.mis = (pc_in[1:0] != 2'b00);
`endif
                e.instr = e.mis ? 32'h0 : imem_word(pc_in);
                expq.push_back(e);
            end
        end
        prev_fl = fl;
    endtask

    initial begin
        bit          acc;
        int          idx;
        int          g0;
        bit          got;
        logic [31:0] rpc;

        rst = 1'b1; pc_valid = 1'b0; pc_in = '0; flush = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_ready", pc_ready, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, RST_PC);
        chk("rst_id_pc_plus4", id_pc_plus4, RST_PC + 32'd4);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("rst_id_misalign", id_misalign, 0);
`endif
        rst = 1'b0;

        // Minimum latency path.
        gnt_lat = 0; rv_lat = 1;
        step(1, 32'h0040_0000, 0, 0, acc);
        chk("t1_accept", acc, 1);
        step(0, 0, 0, 0, acc);
        chk("t1_imem_req", imem_req, 1);
        chk("t1_imem_addr", imem_addr, 32'h0040_0000);
        step(0, 0, 0, 0, acc);
        chk("t1_c2_id_valid", id_valid, 0);
        step(0, 0, 0, 1, acc);
        chk("t1_c3_id_valid", id_valid, 1);
        chk("t1_id_instr", id_instr, 32'h2008_0005);
        chk("t1_id_pc", id_pc, 32'h0040_0000);
        chk("t1_id_pc_plus4", id_pc_plus4, 32'h0040_0004);

        // Queue fills with decode stalled, then drains in order.
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(idx < 3, 32'(idx) * 32'd4, 0, 0, acc);
            if (acc) idx++;
        end
        chk("t2_accepted_two", idx, 2);
        chk("t2_full_pc_ready", pc_ready, 0);
        chk("t2_head_pc", id_pc, 32'h0);
        for (int c = 0; c < 12; c++) begin
            step(idx < 3, 32'(idx) * 32'd4, 0, 1, acc);
            if (acc) idx++;
        end
        chk("t2_accepted_three", idx, 3);
        chk("t2_model_drained", expq.size(), 0);

        // Flush while waiting for data; late response must be dropped.
        gnt_lat = 0; rv_lat = 3;
        step(1, 32'h0000_0300, 0, 0, acc);
        chk("t3_accept", acc, 1);
        step(0, 0, 0, 0, acc);
        step(0, 0, 1, 0, acc);
        step(0, 0, 0, 0, acc);
        chk("t3_drain_pc_ready", pc_ready, 0);
        step(0, 0, 0, 0, acc);
        step(0, 0, 0, 0, acc);
        chk("t3_dropped_id_valid", id_valid, 0);
        rv_lat = 1; got = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(!got, 32'h0000_0100, 0, 1, acc);
            if (acc) got = 1'b1;
        end
        chk("t3_next_fetch_accepted", got, 1);
        chk("t3_model_drained", expq.size(), 0);

        // Flush coinciding with rvalid and a pop on a one-entry queue.
        rv_lat = 2;
        step(1, 32'h0000_0500, 0, 0, acc);
        chk("t4_accept_a", acc, 1);
        repeat (4) step(0, 0, 0, 0, acc);
        chk("t4_one_entry", id_valid, 1);
        step(1, 32'h0000_0504, 0, 0, acc);
        chk("t4_accept_b", acc, 1);
        step(0, 0, 0, 0, acc);
        step(0, 0, 0, 0, acc);
        step(0, 0, 1, 1, acc);
        step(0, 0, 0, 0, acc);
        chk("t4_idle_pc_ready", pc_ready, 1);
        step(0, 0, 0, 0, acc);
        chk("t4_still_empty", id_valid, 0);

        // Slow grant: request held stable, issued once.
        gnt_lat = 5; rv_lat = 1; g0 = n_grant;
        step(1, 32'h0000_0600, 0, 0, acc);
        chk("t5_accept", acc, 1);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0, acc);
            chk("t5_req_held", imem_req, 1);
            chk("t5_addr_held", imem_addr, 32'h0000_0600);
        end
        gnt_lat = 0;
        repeat (6) step(0, 0, 0, 1, acc);
        chk("t5_single_grant", n_grant - g0, 1);
        chk("t5_model_drained", expq.size(), 0);

`ifdef IFETCH_ALIGN_CHECK_EN
        g0 = n_grant;
        step(1, 32'h0040_0002, 0, 0, acc);
        chk("t6_accept", acc, 1);
        step(0, 0, 0, 0, acc);
        chk("t6_no_req", imem_req, 0);
        chk("t6_id_valid", id_valid, 1);
        chk("t6_id_misalign", id_misalign, 1);
        chk("t6_id_instr", id_instr, 0);
        chk("t6_id_pc", id_pc, 32'h0040_0002);
        step(0, 0, 0, 1, acc);
        chk("t6_no_grant", n_grant - g0, 0);
`endif

        // Randomized traffic against the queue model.
        rand_lat = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            rpc = $urandom() & 32'hFFFF_FFFC;
`ifdef IFETCH_ALIGN_CHECK_EN
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
`endif
            step(bit'($urandom_range(0, 1)), rpc, ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) != 0), acc);
        end
        rand_lat = 1'b0; gnt_lat = 0; rv_lat = 1;
        repeat (30) step(0, 0, 0, 1, acc);
        chk("final_model_drained", expq.size(), 0);
        chk("final_id_valid", id_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
